// File: rtl/gpr_file_sb_pkg.sv
// Shared constants and types for the general-purpose register file slice.
package gpr_file_sb_pkg;

    // Default register data width and address width.
    localparam int GPR_DATA_W = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int GPR_NREG   = 2 ** GPR_ADDR_W;

    // Register address at the default geometry.
    typedef logic [GPR_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Within a cycle: a write clears its target's bit, a claim on the same target
// overrides that clear, and flush overrides everything.
module gpr_scoreboard
    import gpr_file_sb_pkg::*;
#(
    parameter int ADDR_W  = GPR_ADDR_W,
    parameter int ZERO_R0 = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   claim_en,
    input  logic [ADDR_W-1:0]      claim_addr,
    input  logic                   we_0,
    input  logic [ADDR_W-1:0]      wr_addr_0,
    input  logic                   we_1,
    input  logic [ADDR_W-1:0]      wr_addr_1,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      rd_addr_0,
    input  logic [ADDR_W-1:0]      rd_addr_1,
    output logic [2**ADDR_W-1:0]   busy_vec,
    output logic                   rd_busy_0,
    output logic                   rd_busy_1
);

    logic [2**ADDR_W-1:0] busy;
    logic [2**ADDR_W-1:0] busy_next;

    // Next busy state: write clears, claim sets (claim wins), flush clears all.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            if ((we_0 && wr_addr_0 == ADDR_W'(i)) || (we_1 && wr_addr_1 == ADDR_W'(i)))
                busy_next[i] = 1'b0;
            if (claim_en && claim_addr == ADDR_W'(i))
                busy_next[i] = 1'b1;
        end
        if (flush)
            busy_next = '0;
        if (ZERO_R0 != 0)
            busy_next[0] = 1'b0;
    end

    // Busy bit register; reset discards every pending mark immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // Read port 0 busy: a same-cycle write releases the register early unless re-claimed.
    always_comb begin
        rd_busy_0 = busy[rd_addr_0];
        if (((we_0 && wr_addr_0 == rd_addr_0) || (we_1 && wr_addr_1 == rd_addr_0)) &&
            !(claim_en && claim_addr == rd_addr_0))
            rd_busy_0 = 1'b0;
    end

    // Read port 1 busy: same early-release rule as port 0.
    always_comb begin
        rd_busy_1 = busy[rd_addr_1];
        if (((we_0 && wr_addr_0 == rd_addr_1) || (we_1 && wr_addr_1 == rd_addr_1)) &&
            !(claim_en && claim_addr == rd_addr_1))
            rd_busy_1 = 1'b0;
    end

    assign busy_vec = busy;

endmodule

// File: rtl/gpr_file_sb.sv
// Two-read / two-write register file with same-cycle write bypass and a
// pending-write scoreboard. Write port 1 (load) has priority over port 0 (ALU).
module gpr_file_sb
    import gpr_file_sb_pkg::*;
#(
    parameter int DATA_W  = GPR_DATA_W,
    parameter int ADDR_W  = GPR_ADDR_W,
    parameter int ZERO_R0 = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      rd_addr_0,
    input  logic [ADDR_W-1:0]      rd_addr_1,
    output logic [DATA_W-1:0]      rd_data_0,
    output logic [DATA_W-1:0]      rd_data_1,
    output logic                   rd_busy_0,
    output logic                   rd_busy_1,
    input  logic                   we_0,
    input  logic [ADDR_W-1:0]      wr_addr_0,
    input  logic [DATA_W-1:0]      wr_data_0,
    input  logic                   we_1,
    input  logic [ADDR_W-1:0]      wr_addr_1,
    input  logic [DATA_W-1:0]      wr_data_1,
    input  logic                   claim_en,
    input  logic [ADDR_W-1:0]      claim_addr,
    input  logic                   flush,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    // True when the address is the hardwired zero register.
    function automatic logic is_r0(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    // Storage: port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            if (we_0 && !is_r0(wr_addr_0))
                regs[wr_addr_0] <= wr_data_0;
            if (we_1 && !is_r0(wr_addr_1))
                regs[wr_addr_1] <= wr_data_1;
        end
    end

    // Read port 0: storage, then port 0 bypass, then port 1 bypass; zero in reset or on r0.
    always_comb begin
        rd_data_0 = regs[rd_addr_0];
        if (we_0 && wr_addr_0 == rd_addr_0)
            rd_data_0 = wr_data_0;
        if (we_1 && wr_addr_1 == rd_addr_0)
            rd_data_0 = wr_data_1;
        if (!rst || is_r0(rd_addr_0))
            rd_data_0 = '0;
    end

    // Read port 1: same priority as port 0.
    always_comb begin
        rd_data_1 = regs[rd_addr_1];
        if (we_0 && wr_addr_0 == rd_addr_1)
            rd_data_1 = wr_data_0;
        if (we_1 && wr_addr_1 == rd_addr_1)
            rd_data_1 = wr_data_1;
        if (!rst || is_r0(rd_addr_1))
            rd_data_1 = '0;
    end

    gpr_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .we_0       (we_0),
        .wr_addr_0  (wr_addr_0),
        .we_1       (we_1),
        .wr_addr_1  (wr_addr_1),
        .flush      (flush),
        .rd_addr_0  (rd_addr_0),
        .rd_addr_1  (rd_addr_1),
        .busy_vec   (busy_vec),
        .rd_busy_0  (rd_busy_0),
        .rd_busy_1  (rd_busy_1)
    );

endmodule

// File: doc/gpr_file_sb.md
GPR_FILE_SB -- requirements
Module: gpr_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; register count NREG = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_R0, default 1, which when 1 hardwires register 0 to zero.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rd_addr_0, rd_addr_1  input  ADDR_W  read port addresses.
REQ-007 rd_data_0, rd_data_1  output  DATA_W  read data.
REQ-008 rd_busy_0, rd_busy_1  output  1  addressed register has a pending write.
REQ-009 we_0, wr_addr_0, wr_data_0  input  1/ADDR_W/DATA_W  write port 0 (ALU writeback).
REQ-010 we_1, wr_addr_1, wr_data_1  input  1/ADDR_W/DATA_W  write port 1 (load writeback).
REQ-011 claim_en, claim_addr  input  1/ADDR_W  marks a destination register pending.
REQ-012 flush  input  1  clears all pending marks.
REQ-013 busy_vec  output  NREG  per-register pending bits.

Function
REQ-014 Reads SHALL be combinational; rd_data SHALL equal the stored value unless bypassed.
REQ-015 Bypass: a read SHALL return wr_data_1 if we_1 and wr_addr_1 match the read address, otherwise wr_data_0 if we_0 and wr_addr_0 match.
REQ-016 A write SHALL update storage at the next rising clk edge; the data is visible without bypass from the following cycle.
REQ-017 If both write ports target the same address in one cycle, port 1 SHALL win in storage and in bypass.
REQ-018 claim_en SHALL set busy[claim_addr] at the next edge.
REQ-019 A write on either port SHALL clear busy[wr_addr] at the next edge.
REQ-020 If a claim and a write target the same address in one cycle, busy SHALL end at 1, because the claim wins.
REQ-021 rd_busy_n SHALL reflect the registered busy bit, cleared combinationally when a same-cycle write hits that address and no same-cycle claim hits it.
REQ-022 flush SHALL clear all busy bits at the next edge and SHALL override claims in the same cycle; writes still update storage.
REQ-023 With ZERO_R0=1, register 0 SHALL:
- read 0, including through bypass;
- ignore writes and claims;
- report busy as 0.
REQ-024 With ZERO_R0=0, register 0 SHALL behave like any other register.

Reset
REQ-025 While rst is low, all registers and all busy bits SHALL be 0, so rd_data_* = 0, rd_busy_* = 0 and busy_vec = 0.
REQ-026 Reset asserted mid-operation SHALL discard pending writes and claims immediately.
REQ-027 Writes and claims SHALL NOT take effect on the first edge after rst deasserts unless they are presented in that cycle.

Structure
REQ-028 A shared package SHALL hold the default DATA_W/ADDR_W constants and the register-address typedef.
REQ-029 The scoreboard SHALL be one sub-module, gpr_scoreboard (busy bits, claim/clear/flush priority).
REQ-030 Storage and bypass SHALL live in the top level.

Verification
REQ-031 Scenario: reset, then read x5 -> rd_data = 0, rd_busy = 0, busy_vec = 0.
REQ-032 Scenario: we_0 x7 = 0xDEADBEEF while reading x7 in the same cycle -> rd_data = 0xDEADBEEF that cycle and the next.
REQ-033 Scenario: we_0 x3 = 0x11 and we_1 x3 = 0x22 in the same cycle -> bypass returns 0x22; the stored value is 0x22.
REQ-034 Scenario: claim x9; next cycle -> rd_busy = 1; a later we_1 x9 -> rd_busy = 0 in the write cycle (combinational) and busy[9] = 0 after the edge.
REQ-035 Scenario: claim x4 together with we_0 x4 -> busy[4] = 1 after the edge; then flush with claim x4 -> busy[4] = 0.
REQ-036 Scenario: ZERO_R0=1, we_0 x0 = 0xFFFF plus claim x0 -> rd_data x0 = 0 and busy[0] = 0 in all cycles; rst pulsed low mid-sequence -> all outputs 0 immediately.
